vid_scanout: RTL

VID_SCANOUT -- requirements
Module: vid_scanout

---
 rtl/vid_scanout.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vid_scanout.sv
// Raster timing generator with framebuffer scan-out: prefetches 32-bit words into a
// small FIFO ahead of the beam and unpacks them into RGB444 (16bpp) or RGB332 (8bpp) pixels.
module vid_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned AW         = 24,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          mode,
    input  logic [AW-1:0] base,
    output logic          req,
    output logic [AW-1:0] adr,
    input  logic          ack,
    input  logic [31:0]   viddata,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [11:0]   RGB,
    output logic          vbl,
    output logic          underflow,
    input  logic          clr_uf
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned WORDS0   = (H_ACTIVE * V_ACTIVE) / 2;
    localparam int unsigned WORDS1   = (H_ACTIVE * V_ACTIVE) / 4;
    localparam int unsigned BW       = $clog2(WORDS0 + 1);
    localparam int unsigned FAW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW       = FAW + 1;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_REQ  = 1'b1
    } fetch_state_t;

    // Raster position and frame state
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          start_pend;
    logic          fmode;
    logic [BW-1:0] budget;

    // Fetch FSM and FIFO
    fetch_state_t   fstate;
    fetch_state_t   fstate_nx;
    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0] wptr;
    logic [FAW-1:0] rptr;
    logic [CW-1:0]  fcnt;
    logic [1:0]     phase;

    // Combinational decode
    logic        h_last_c;
    logic        v_last_c;
    logic        fs_c;
    logic        active_c;
    logic        hs_act_c;
    logic        vs_act_c;
    logic        full_c;
    logic        empty_c;
    logic        push_c;
    logic        pop_c;
    logic        last_phase_c;
    logic        uf_c;
    logic [31:0] head_c;
    logic [7:0]  pix8_c;
    logic [11:0] pix_c;

    assign h_last_c = (32'(hcnt) == H_TOTAL - 1);
    assign v_last_c = (32'(vcnt) == V_TOTAL - 1);
    assign active_c = (32'(hcnt) < H_ACTIVE) && (32'(vcnt) < V_ACTIVE);
    assign hs_act_c = (32'(hcnt) >= HS_START) && (32'(hcnt) < HS_END);
    assign vs_act_c = (32'(vcnt) >= VS_START) && (32'(vcnt) < VS_END);

    // Frame start: first cycle out of reset, or the ce step into the first vblank line
    assign fs_c = start_pend || (ce && h_last_c && (32'(vcnt) == V_ACTIVE - 1));

    assign full_c       = (fcnt == CW'(FIFO_DEPTH));
    assign empty_c      = (fcnt == '0);
    assign last_phase_c = fmode ? (phase == 2'd3) : phase[0];
    assign pop_c        = ce && active_c && !empty_c && last_phase_c && !fs_c;
    assign uf_c         = ce && active_c && empty_c;
    assign head_c       = fifo_mem[rptr];
    assign req          = (fstate == F_REQ);

    // Raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt       <= '0;
            vcnt       <= VW'(V_ACTIVE);
            start_pend <= 1'b1;
        end else begin
            start_pend <= 1'b0;
            if (ce) begin
                if (h_last_c) begin
                    hcnt <= '0;
                    vcnt <= v_last_c ? '0 : vcnt + VW'(1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end
        end
    end

    // Fetch FSM: one outstanding request; frame start cancels whatever is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            fstate <= F_IDLE;
        end else begin
            fstate <= fstate_nx;
        end
    end

    always_comb begin
        fstate_nx = fstate;
        push_c    = 1'b0;
        case (fstate)
            F_IDLE: begin
                if ((budget != '0) && !full_c) begin
                    fstate_nx = F_REQ;
                end
            end
            F_REQ: begin
                if (ack) begin
                    fstate_nx = F_IDLE;
                    push_c    = 1'b1;
                end
            end
            default: fstate_nx = F_IDLE;
        endcase
        if (fs_c) begin
            fstate_nx = F_IDLE;
            push_c    = 1'b0;
        end
    end

    // Frame registers, address and word budget
    always_ff @(posedge clk) begin
        if (rst) begin
            adr    <= '0;
            budget <= '0;
            fmode  <= 1'b0;
        end else if (fs_c) begin
            adr    <= base;
            budget <= mode ? BW'(WORDS1) : BW'(WORDS0);
            fmode  <= mode;
        end else if (push_c) begin
            adr    <= adr + AW'(1);
            budget <= budget - BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            fifo_mem[wptr] <= viddata;
        end
    end

    // FIFO pointers and occupancy; flushed at every frame start
    always_ff @(posedge clk) begin
        if (rst || fs_c) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
        end else begin
            if (push_c) begin
                wptr <= wptr + FAW'(1);
            end
            if (pop_c) begin
                rptr <= rptr + FAW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fcnt <= fcnt + CW'(1);
                2'b01:   fcnt <= fcnt - CW'(1);
                default: fcnt <= fcnt;
            endcase
        end
    end

    // Pixel unpack from the FIFO head word
    always_comb begin
        case (phase)
            2'd0:    pix8_c = head_c[7:0];
            2'd1:    pix8_c = head_c[15:8];
            2'd2:    pix8_c = head_c[23:16];
            default: pix8_c = head_c[31:24];
        endcase
        if (fmode) begin
            pix_c = {pix8_c[7:5], pix8_c[7], pix8_c[4:2], pix8_c[4], pix8_c[1:0], pix8_c[1:0]};
        end else begin
            pix_c = phase[0] ? head_c[27:16] : head_c[11:0];
        end
    end

    // Video outputs, one ce step behind the counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
            de        <= 1'b0;
            RGB       <= '0;
            vbl       <= 1'b0;
            underflow <= 1'b0;
            phase     <= '0;
        end else begin
            vbl <= fs_c;
            if (uf_c) begin
                underflow <= 1'b1;
            end else if (clr_uf) begin
                underflow <= 1'b0;
            end
            if (ce) begin
                hsync <= hs_act_c ? HS_POL : ~HS_POL;
                vsync <= vs_act_c ? VS_POL : ~VS_POL;
                de    <= active_c;
                RGB   <= (active_c && !empty_c) ? pix_c : 12'h000;
            end
            // Phase keeps stepping through starved pixels so the line end realigns it
            if (ce && active_c) begin
                if (last_phase_c || (32'(hcnt) == H_ACTIVE - 1)) begin
                    phase <= '0;
                end else begin
                    phase <= phase + 2'd1;
                end
            end else if (fs_c) begin
                phase <= '0;
            end
        end
    end

endmodule
